// File: rtl/lc2k_control.sv
// LC2K multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Outputs are decoded from the state register and instr with zero added latency.
// FETCH, MEM_RD and MEM_WR hold until mem_ready; an access aborted by reset idles one cycle.
module lc2k_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   input  logic             alu_beq,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             rf_we,
   output logic [2:0]       rf_waddr,
   output logic [1:0]       rf_wsel,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_RD,
      S_WB_LW, S_MEM_WR, S_BRANCH, S_JALR, S_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             abort_q, abort_d;
   logic             rst_q, rst_d;

   logic [2:0] opcode;
   logic [2:0] reg_b;
   logic [2:0] dest_reg;
   logic       unused_instr_bits;

   assign opcode            = instr[24:22];
   assign reg_b             = instr[18:16];
   assign dest_reg          = instr[2:0];
   assign unused_instr_bits = ^{instr[31:25], instr[21:19], instr[15:3]};

   // Abort bookkeeping: the first reset cycle that lands on a live memory
   // request schedules one idle cycle after reset, so the access is dropped
   // before FETCH raises a fresh request.
   always_comb begin
      rst_d   = reset;
      abort_d = reset & ~rst_q &
                ((state_q == S_FETCH) | (state_q == S_MEM_RD) | (state_q == S_MEM_WR));
      count_d = (state_q == S_DECODE) ? count_q + CNT_W'(1) : count_q;
   end

   // State, counter and abort flags; reset wins over mem_ready
   always_ff @(posedge clk) begin
      rst_q   <= rst_d;
      abort_q <= abort_d;
      if (reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state: sequence by state and opcode, holding on memory waits
   always_comb begin
      state_d = state_q;
      if (!abort_q) begin
         case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
               case (opcode)
                  3'b000, 3'b001: state_d = S_EXEC_R;
                  3'b010, 3'b011: state_d = S_ADDR;
                  3'b100:         state_d = S_BRANCH;
                  3'b101:         state_d = S_JALR;
                  3'b110:         state_d = S_HALT;
                  default:        state_d = S_FETCH;
               endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_ADDR:   state_d = opcode[0] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) state_d = S_WB_LW;
            S_WB_LW:  state_d = S_FETCH;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JALR:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   // Output decode: everything defaults to 0, the idle abort cycle drives nothing
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      alu_op       = 2'b00;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      rf_we        = 1'b0;
      rf_waddr     = 3'd0;
      rf_wsel      = 2'd0;
      halted       = (state_q == S_HALT);
      if (!abort_q) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'd2;
               ir_load   = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd1;
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = {1'b0, opcode[0]};
            end
            S_WB_R: begin
               rf_we    = 1'b1;
               rf_waddr = dest_reg;
            end
            S_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd1;
            end
            S_MEM_RD: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
            end
            S_WB_LW: begin
               rf_we    = 1'b1;
               rf_waddr = reg_b;
               rf_wsel  = 2'd1;
            end
            S_MEM_WR: begin
               mem_req      = 1'b1;
               mem_we       = 1'b1;
               mem_addr_sel = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               pc_write  = alu_beq;
               pc_src    = alu_beq ? 2'd1 : 2'd0;
            end
            S_JALR: begin
               rf_we    = 1'b1;
               rf_waddr = reg_b;
               rf_wsel  = 2'd2;
               pc_write = 1'b1;
               pc_src   = 2'd2;
            end
            default: ;
         endcase
      end
   end

   assign instr_count = count_q;

endmodule

// File: tb/tb_lc2k_control.sv
// Bench for lc2k_control: per-instruction reference sequences feed a scoreboard.
// Expected control vectors are queued each cycle and compared mid-cycle.
// Memory wait states and branch outcomes are randomized.
module tb_lc2k_control;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      instr;
   logic             mem_ready;
   logic             alu_beq;
   logic             mem_req, mem_we, mem_addr_sel, ir_load, pc_write;
   logic [1:0]       pc_src, alu_op, alu_src_b, rf_wsel;
   logic             alu_src_a, rf_we, halted;
   logic [2:0]       rf_waddr;
   logic [CNT_W-1:0] instr_count;

   always #5 clk = ~clk;

   lc2k_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_beq(alu_beq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
      .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
      .halted(halted), .instr_count(instr_count)
   );

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        mem_addr_sel;
      logic        ir_load;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic [1:0]  alu_op;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      logic        rf_we;
      logic [2:0]  rf_waddr;
      logic [1:0]  rf_wsel;
      logic        halted;
      logic [31:0] cnt;
   } ctl_t;

   ctl_t        exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_count = 0;

   // Scoreboard monitor: one expected vector per checked cycle
   always @(negedge clk) begin
      ctl_t  act, expv;
      string tag;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         tag  = tag_q.pop_front();
         act  = {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src, alu_op,
                 alu_src_a, alu_src_b, rf_we, rf_waddr, rf_wsel, halted, instr_count};
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, act, expv);
         end
      end
   end

   function automatic ctl_t blank();
      ctl_t c = '0;
      c.cnt = model_count;
      return c;
   endfunction

   task automatic step(input ctl_t e, input string tag, input logic rdy, input logic beq);
      mem_ready = rdy;
      alu_beq   = beq;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'($urandom);
         @(posedge clk);
         #1;
      end
      reset       = 1'b0;
      model_count = 0;
   endtask

   task automatic do_fetch(input int waits);
      ctl_t c;
      for (int i = 0; i <= waits; i++) begin
         c           = blank();
         c.mem_req   = 1'b1;
         c.alu_src_b = 2'd2;
         if (i == waits) begin
            c.ir_load  = 1'b1;
            c.pc_write = 1'b1;
         end
         instr = $urandom;
         step(c, "fetch", i == waits, 1'($urandom));
      end
   endtask

   task automatic mem_phase(input int waits, input logic wr);
      ctl_t c;
      for (int i = 0; i <= waits; i++) begin
         c              = blank();
         c.mem_req      = 1'b1;
         c.mem_we       = wr;
         c.mem_addr_sel = 1'b1;
         step(c, wr ? "mem_wr" : "mem_rd", i == waits, 1'($urandom));
      end
   endtask

   // Reference: one instruction from fetch to its last cycle
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic beq, input int halt_hold);
      ctl_t       c;
      logic [2:0] op, rb, rd;
      op = ins[24:22];
      rb = ins[18:16];
      rd = ins[2:0];
      do_fetch(fw);
      instr       = ins;
      c           = blank();
      c.alu_src_b = 2'd1;
      step(c, "decode", 1'($urandom), 1'($urandom));
      model_count = model_count + 1;
      case (op)
         3'd0, 3'd1: begin
            c           = blank();
            c.alu_src_a = 1'b1;
            c.alu_op    = (op == 3'd1) ? 2'b01 : 2'b00;
            step(c, "exec_r", 1'($urandom), 1'($urandom));
            c          = blank();
            c.rf_we    = 1'b1;
            c.rf_waddr = rd;
            step(c, "wb_r", 1'($urandom), 1'($urandom));
         end
         3'd2, 3'd3: begin
            c           = blank();
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd1;
            step(c, "addr", 1'($urandom), 1'($urandom));
            mem_phase(mw, op == 3'd3);
            if (op == 3'd2) begin
               c          = blank();
               c.rf_we    = 1'b1;
               c.rf_waddr = rb;
               c.rf_wsel  = 2'd1;
               step(c, "wb_lw", 1'($urandom), 1'($urandom));
            end
         end
         3'd4: begin
            c           = blank();
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
            c.pc_write  = beq;
            c.pc_src    = beq ? 2'd1 : 2'd0;
            step(c, beq ? "beq_taken" : "beq_not_taken", 1'($urandom), beq);
         end
         3'd5: begin
            c          = blank();
            c.rf_we    = 1'b1;
            c.rf_waddr = rb;
            c.rf_wsel  = 2'd2;
            c.pc_write = 1'b1;
            c.pc_src   = 2'd2;
            step(c, "jalr", 1'($urandom), 1'($urandom));
         end
         3'd6: begin
            for (int i = 0; i < halt_hold; i++) begin
               c        = blank();
               c.halted = 1'b1;
               step(c, "halt_hold", 1'($urandom), 1'($urandom));
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      ctl_t        c;
      logic [31:0] ins;
      logic [2:0]  op;
      reset     = 1'b1;
      instr     = '0;
      mem_ready = 1'b0;
      alu_beq   = 1'b0;

      // Directed sequences
      do_reset();
      run_instr(32'h0005_0002, 0, 0, 1'b0, 0);   // add r0,r5 -> r2
      run_instr(32'h008A_0003, 0, 3, 1'b0, 0);   // lw, 3 wait cycles
      run_instr(32'h0108_0005, 0, 0, 1'b1, 0);   // beq taken
      run_instr(32'h0108_0005, 1, 0, 1'b0, 0);   // beq not taken
      run_instr(32'h0146_0000, 0, 0, 1'b0, 0);   // jalr, regB=6
      run_instr(32'h0180_0000, 0, 0, 1'b0, 12);  // halt

      // Randomized instruction stream
      do_reset();
      for (int n = 0; n < 300; n++) begin
         ins = $urandom;
         op  = ($urandom_range(0, 40) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
         if (op == 3'd6) op = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
         ins[24:22] = op;
         run_instr(ins, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   1'($urandom), 3);
         if (op == 3'd6) do_reset();
      end

      // Reset during a sw wait with mem_ready high in the reset cycle
      do_reset();
      do_fetch(0);
      instr       = 32'h00C0_0007;
      c           = blank();
      c.alu_src_b = 2'd1;
      step(c, "decode_sw", 1'b0, 1'b0);
      model_count = model_count + 1;
      c           = blank();
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'd1;
      step(c, "addr_sw", 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         c              = blank();
         c.mem_req      = 1'b1;
         c.mem_we       = 1'b1;
         c.mem_addr_sel = 1'b1;
         step(c, "mem_wr_wait", 1'b0, 1'b0);
      end
      reset = 1'b1;
      step(c, "mem_wr_reset_cycle", 1'b1, 1'b0);
      reset       = 1'b0;
      model_count = 0;
      c           = blank();
      step(c, "post_reset_idle", 1'b1, 1'b0);
      run_instr(32'h01C0_0000, 0, 0, 1'b0, 0);   // noop after recovery
      run_instr(32'h0045_0001, 2, 0, 1'b0, 0);   // nor after recovery

      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc2k_control.md
# lc2k_control

Multicycle control FSM for the LC2K datapath. It sits directly upstream of the ALU and sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the ALU operation code and operand selects, and it consumes the ALU's branch-equal flag. It also drives the PC, instruction-register, register-file and memory-handshake controls.

## Interface
- `CNT_W`, default 32: width of the `instr_count` counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `instr`  in  32: instruction register contents. Opcode is [24:22], regA [21:19], regB [18:16], destReg [2:0].
- `mem_ready`  in  1: memory completion; sampled only while `mem_req`=1.
- `alu_beq`  in  1: ALU equal flag; valid the same cycle `alu_op`=2'b10.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: 1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr_sel`  out  1: memory address source; 0 = PC, 1 = ALUOut register.
- `ir_load`  out  1: load the instruction register from memory read data.
- `pc_write`  out  1: load the PC.
- `pc_src`  out  2: PC source; 0 = ALU result, 1 = ALUOut register, 2 = regA value.
- `alu_op`  out  2: 00 = add, 01 = nor, 10 = equal.
- `alu_src_a`  out  1: ALU operand A; 0 = PC, 1 = regA value.
- `alu_src_b`  out  2: ALU operand B; 0 = regB value, 1 = sign-extended offset[15:0], 2 = constant 1.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  3: register-file write address.
- `rf_wsel`  out  2: write data; 0 = ALUOut, 1 = memory read data, 2 = PC.
- `halted`  out  1: high once a halt instruction has been decoded.
- `instr_count`  out  CNT_W: count of decoded instructions.

## Operation
- **Datapath assumptions.** The ALUOut register loads the ALU result every cycle. The register file reads combinationally and writes on the clock edge.
- **States:** FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LW, MEM_WR, BRANCH, JALR, HALT.
- **FETCH**
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0, `alu_src_a`=0, `alu_src_b`=2, `alu_op`=00.
  - Waits for `mem_ready`=1. In that cycle it asserts `ir_load`=1 and `pc_write`=1 with `pc_src`=0 (PC ← PC+1), then goes to DECODE.
- **DECODE**
  - Drives `alu_src_a`=0, `alu_src_b`=1, `alu_op`=00, so ALUOut ← PC+1+offset (branch target).
  - Increments `instr_count`, wrapping modulo 2^CNT_W.
  - Next state by opcode: 000/001 → EXEC_R; 010/011 → ADDR; 100 → BRANCH; 101 → JALR; 110 → HALT; 111 → FETCH.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=0, `alu_op` = opcode[0] (add or nor). Next state WB_R.
- **WB_R:** `rf_we`=1, `rf_waddr`=destReg, `rf_wsel`=0. Next state FETCH.
- **ADDR:** `alu_src_a`=1, `alu_src_b`=1, `alu_op`=00. Next state MEM_RD for lw, MEM_WR for sw.
- **MEM_RD:** `mem_req`=1, `mem_we`=0, `mem_addr_sel`=1. Holds until `mem_ready`, then goes to WB_LW.
- **WB_LW:** `rf_we`=1, `rf_waddr`=regB, `rf_wsel`=1. Next state FETCH.
- **MEM_WR:** `mem_req`=1, `mem_we`=1, `mem_addr_sel`=1. Holds until `mem_ready`, then goes to FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=0, `alu_op`=10. When `alu_beq`=1, asserts `pc_write`=1 with `pc_src`=1. Next state FETCH.
- **JALR:**
  - Asserts `rf_we`=1, `rf_waddr`=regB, `rf_wsel`=2, and `pc_write`=1 with `pc_src`=2, all in the same cycle.
  - The register file is read before the edge, so regA = regB behaves correctly (PC gets the old value).
  - Next state FETCH.
- **HALT:** `halted`=1 and stays in HALT until reset.
- **Default outputs.** Any output not listed for a state is 0.

## Timing
- **Reset:** state → FETCH, `instr_count` → 0, `halted` → 0.
- **Reset mid-access:** an in-flight memory access is abandoned. `mem_req` is 0 in the first cycle after a reset cycle, and `mem_req` is reasserted in FETCH the cycle after that. Reset overrides `mem_ready` in the same cycle.
- **Output decoding:**
  - Outputs are decoded from the state register and `instr`.
  - Only `ir_load` and FETCH's `pc_write` are gated by `mem_ready`; BRANCH's `pc_write` is gated by `alu_beq`.
- **Memory handshake:**
  - While waiting, `mem_req`, `mem_we` and `mem_addr_sel` stay constant.
  - Zero-wait access (`mem_ready`=1 in the first request cycle) is legal.
  - `mem_ready` has no effect outside FETCH, MEM_RD and MEM_WR.
- **Cycles per instruction with zero-wait memory** (each wait cycle adds 1):
  - add/nor: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - jalr: 3
  - noop: 2
- **Halt:** `halted` rises on the edge leaving DECODE.

## Test plan
- **Reset and first fetch:** assert reset for 2 cycles, then release. Required: `mem_req`=1 in the first cycle after release, `instr_count`=0, `halted`=0, all other outputs 0.
- **add:** instr=0x00050002 (add r0,r5→r2), zero-wait memory. Required:
  - FETCH→DECODE→EXEC_R→WB_R, with `alu_op`=00 and `alu_src_b`=0 in EXEC_R.
  - `rf_we`=1 and `rf_waddr`=2 in cycle 4.
  - `instr_count`=1.
- **lw with 3 wait cycles on MEM_RD:** instr=0x008A0003. Required: `mem_req`/`mem_addr_sel` held at 1 for 4 cycles, then WB_LW with `rf_waddr`=2 and `rf_wsel`=1.
- **beq:** instr=0x01080005.
  - With `alu_beq`=1 in BRANCH: `pc_write`=1 and `pc_src`=1.
  - Repeat with `alu_beq`=0: `pc_write`=0 in BRANCH.
  - Both cases return to FETCH.
- **jalr then halt:** instr=0x01460000, then 0x01800000. Required:
  - JALR asserts `rf_waddr`=6, `rf_wsel`=2, `pc_src`=2.
  - After the halt, `halted`=1 stays high for 10+ cycles with `mem_req`=0, and `instr_count`=2.
- **Reset mid-access:** assert reset during a MEM_WR wait with `mem_ready`=1 in the same cycle. Required: `mem_req`=0 in the first cycle after reset, state returns to FETCH, and the write is not completed.
